// File: rtl/alu_ex_pipe.sv
// Execute stage: single-cycle ALU/branch/address ops, multi-cycle signed multiply,
// valid/ready handshake to MEM and a sticky HALT.
module alu_ex_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REGA       = 5,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned ADDR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc4,
  input  logic            mem_read_in,
  input  logic            mem_to_reg_in,
  input  logic            mem_write_in,
  input  logic [REGA-1:0] rd_addr_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_val,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] next_pc,
  output logic            branch_taken,
  output logic            ovf,
  output logic            mem_read_out,
  output logic            mem_to_reg_out,
  output logic            mem_write_out,
  output logic [REGA-1:0] rd_addr_out,
  output logic            busy,
  output logic            halted
);

  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [5:0] OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07;
  localparam logic [5:0] OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B;
  localparam logic [5:0] OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10, OP_HALT = 6'h11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_mul_a, r_mul_b, r_mul_pc4;
  logic              r_mul_mr, r_mul_mtr, r_mul_mw;
  logic [REGA-1:0]   r_mul_rd;

  logic              w_accept, w_is_mul, w_out_free, w_done;
  logic [XLEN-1:0]   w_opb, w_sum, w_diff, w_addr, w_br_tgt;
  logic [XLEN-1:0]   w_rd_val, w_mem_addr, w_next_pc;
  logic              w_taken, w_ovf, w_mul_ovf;
  logic [2*XLEN-1:0] w_mul_a_x, w_mul_b_x, w_prod;

  assign w_out_free = !out_valid || out_ready;
  assign in_ready   = !halted && (r_state == S_IDLE) && w_out_free;
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (op == OP_MUL) || (op == OP_MULI);

  // Odd opcodes in the 00..0B range take imm as the second operand.
  assign w_opb    = op[0] ? imm : rt;
  assign w_sum    = rs + w_opb;
  assign w_diff   = rs - w_opb;
  assign w_addr   = $unsigned($signed(rs) >>> ADDR_SHIFT) + $unsigned($signed(imm) >>> ADDR_SHIFT);
  assign w_br_tgt = pc4 + {imm[XLEN-3:0], 2'b00};

  assign w_mul_a_x = {{XLEN{r_mul_a[XLEN-1]}}, r_mul_a};
  assign w_mul_b_x = {{XLEN{r_mul_b[XLEN-1]}}, r_mul_b};
  assign w_prod    = w_mul_a_x * w_mul_b_x;
  assign w_mul_ovf = (w_prod[2*XLEN-1:XLEN] != {XLEN{w_prod[XLEN-1]}});

  always_comb begin
    w_rd_val   = '0;
    w_mem_addr = '0;
    w_next_pc  = pc4;
    w_taken    = 1'b0;
    w_ovf      = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        w_rd_val = w_sum;
        w_ovf    = (rs[XLEN-1] == w_opb[XLEN-1]) && (w_sum[XLEN-1] != rs[XLEN-1]);
      end
      OP_SUB, OP_SUBI: begin
        w_rd_val = w_diff;
        w_ovf    = (rs[XLEN-1] != w_opb[XLEN-1]) && (w_diff[XLEN-1] != rs[XLEN-1]);
      end
      OP_OR,  OP_ORI:  w_rd_val = rs | w_opb;
      OP_AND, OP_ANDI: w_rd_val = rs & w_opb;
      OP_XOR, OP_XORI: w_rd_val = rs ^ w_opb;
      OP_LDW: w_mem_addr = w_addr;
      OP_STW: begin
        w_mem_addr = w_addr;
        w_rd_val   = rt;
      end
      OP_BZ: if (rs == '0) begin
        w_taken   = 1'b1;
        w_next_pc = w_br_tgt;
      end
      OP_BEQ: if (rs == rt) begin
        w_taken   = 1'b1;
        w_next_pc = w_br_tgt;
      end
      OP_JR: begin
        w_taken   = 1'b1;
        w_next_pc = rs;
      end
      default: ;
    endcase
  end

  // Multiplier sequencing: busy spans MUL_CYCLES cycles including DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_nxt = (MUL_CYCLES <= 1) ? S_DONE : S_MUL;
      S_MUL:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      S_DONE: if (w_out_free) begin
        w_state_nxt = S_IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_pc4 <= '0;
      r_mul_mr  <= 1'b0;
      r_mul_mtr <= 1'b0;
      r_mul_mw  <= 1'b0;
      r_mul_rd  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_is_mul) begin
        r_cnt     <= CNT_W'(MUL_CYCLES - 1);
        r_mul_a   <= rs;
        r_mul_b   <= w_opb;
        r_mul_pc4 <= pc4;
        r_mul_mr  <= mem_read_in;
        r_mul_mtr <= mem_to_reg_in;
        r_mul_mw  <= mem_write_in;
        r_mul_rd  <= rd_addr_in;
      end else if (r_state == S_MUL) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Result registers: written only on completion, otherwise held until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      rd_val         <= '0;
      mem_addr       <= '0;
      next_pc        <= '0;
      branch_taken   <= 1'b0;
      ovf            <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_write_out  <= 1'b0;
      rd_addr_out    <= '0;
      halted         <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      out_valid      <= 1'b1;
      rd_val         <= w_rd_val;
      mem_addr       <= w_mem_addr;
      next_pc        <= w_next_pc;
      branch_taken   <= w_taken;
      ovf            <= w_ovf;
      mem_read_out   <= mem_read_in;
      mem_to_reg_out <= mem_to_reg_in;
      mem_write_out  <= mem_write_in;
      rd_addr_out    <= rd_addr_in;
      if (op == OP_HALT) halted <= 1'b1;
    end else if (w_done) begin
      out_valid      <= 1'b1;
      rd_val         <= w_prod[XLEN-1:0];
      mem_addr       <= '0;
      next_pc        <= r_mul_pc4;
      branch_taken   <= 1'b0;
      ovf            <= w_mul_ovf;
      mem_read_out   <= r_mul_mr;
      mem_to_reg_out <= r_mul_mtr;
      mem_write_out  <= r_mul_mw;
      rd_addr_out    <= r_mul_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
